cook_timer_ctrl: RTL and testbench

Cook-cycle controller for the microwave: consumes debounced keypad digits and the 1 Hz tick from the encoder, assembles a 3-digit BCD cook time (M:SS), and sequences the magnetron through set, cook, pause and done phases. Sits between the encoder and the display/magnetron drivers; owns all time and state registers.

---
 rtl/cook_timer_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_cook_timer_ctrl.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cook_timer_ctrl.sv
// cook_timer_ctrl: microwave cook-cycle controller.
// Assembles a 3-digit BCD cook time (M:SS) from keypad digits and counts it
// down on the 1 Hz tick. It sequences the magnetron through the SET, COOK,
// PAUSE and DONE phases.
// Optional feature macro: COOK_TIMER_QUICK_START_EN. When it is defined, a
// zero-time start loads 0:30, and start while cooking adds 30 s (capped at
// 9:59).
// Ports:
//   clk, reset (sync, active-high)
//   digit/digit_stb  - BCD keypad digit and its strobe (10-15 ignored)
//   tick_1hz         - one-cycle pulse per second
//   start/stop/clear - one-cycle requests
//   door_closed      - level, 1 = door closed
//   min_d/sec_t/sec_o - displayed time (registered)
//   mag_on, done, state - phase outputs (registered)
module cook_timer_ctrl #(
  parameter int unsigned DONE_HOLD = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] digit,
  input  logic       digit_stb,
  input  logic       tick_1hz,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
  input  logic       door_closed,
  output logic [3:0] min_d,
  output logic [3:0] sec_t,
  output logic [3:0] sec_o,
  output logic       mag_on,
  output logic       done,
  output logic [1:0] state
);

  localparam int unsigned DW = 4;
  localparam int unsigned HW = 4;

  typedef enum logic [1:0] {
    S_SET   = 2'b00,
    S_COOK  = 2'b01,
    S_PAUSE = 2'b10,
    S_DONE  = 2'b11
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [DW-1:0] r_min, r_sect, r_seco;
  logic [DW-1:0] w_min_nxt, w_sect_nxt, w_seco_nxt;
  logic [HW-1:0] r_hold, w_hold_nxt;
  logic          r_mag_on, r_done;

  // Priority-resolved events: at most one is active per cycle
  logic w_ev_clear, w_ev_stop, w_ev_start, w_ev_digit, w_ev_tick;
  assign w_ev_clear = clear;
  assign w_ev_stop  = stop & ~clear;
  assign w_ev_start = start & ~stop & ~clear;
  assign w_ev_digit = digit_stb & ~start & ~stop & ~clear;
  assign w_ev_tick  = tick_1hz & ~digit_stb & ~start & ~stop & ~clear;

  logic w_time_zero;
  assign w_time_zero = (r_min == '0) && (r_sect == '0) && (r_seco == '0);

  // One-second decrement; seconds above 59 count down unnormalised
  logic [DW-1:0] w_dec_min, w_dec_sect, w_dec_seco;
  logic          w_dec_zero;
  always_comb begin
    w_dec_min  = r_min;
    w_dec_sect = r_sect;
    w_dec_seco = r_seco;
    if (r_seco != '0) begin
      w_dec_seco = r_seco - DW'(1);
    end else if (r_sect != '0) begin
      w_dec_seco = DW'(9);
      w_dec_sect = r_sect - DW'(1);
    end else begin
      w_dec_min  = r_min - DW'(1);
      w_dec_sect = DW'(5);
      w_dec_seco = DW'(9);
    end
  end
  assign w_dec_zero = (w_dec_min == '0) && (w_dec_sect == '0) && (w_dec_seco == '0);

`ifdef COOK_TIMER_QUICK_START_EN
  // Add 30 s: tens digit +3 with carry into minutes, capped at 9:59
  logic [DW-1:0] w_add_sum, w_add_min, w_add_sect;
  logic          w_add_sat;
  always_comb begin
    w_add_sum  = r_sect + DW'(3);
    w_add_min  = r_min;
    w_add_sect = w_add_sum;
    if (w_add_sum >= DW'(6)) begin
      w_add_sect = w_add_sum - DW'(6);
      w_add_min  = r_min + DW'(1);
    end
  end
  assign w_add_sat = (w_add_min > DW'(9));
`endif

  // Next-state and next-time logic
  always_comb begin
    w_state_nxt = r_state;
    w_min_nxt   = r_min;
    w_sect_nxt  = r_sect;
    w_seco_nxt  = r_seco;
    w_hold_nxt  = r_hold;
    case (r_state)
      S_SET: begin
        if (w_ev_clear) begin
          w_min_nxt  = '0;
          w_sect_nxt = '0;
          w_seco_nxt = '0;
        end else if (w_ev_start && door_closed) begin
          if (!w_time_zero) begin
            w_state_nxt = S_COOK;
          end
`ifdef COOK_TIMER_QUICK_START_EN
          else begin
            w_sect_nxt  = DW'(3);
            w_state_nxt = S_COOK;
          end
`endif
        end else if (w_ev_digit && (digit <= DW'(9))) begin
          w_min_nxt  = r_sect;
          w_sect_nxt = r_seco;
          w_seco_nxt = digit;
        end
      end
      S_COOK: begin
        if (!door_closed || w_ev_stop) begin
          w_state_nxt = S_PAUSE;
        end else if (w_ev_start) begin
`ifdef COOK_TIMER_QUICK_START_EN
          if (w_add_sat) begin
            w_min_nxt  = DW'(9);
            w_sect_nxt = DW'(5);
            w_seco_nxt = DW'(9);
          end else begin
            w_min_nxt  = w_add_min;
            w_sect_nxt = w_add_sect;
          end
`endif
        end else if (w_ev_tick) begin
          w_min_nxt  = w_dec_min;
          w_sect_nxt = w_dec_sect;
          w_seco_nxt = w_dec_seco;
          if (w_dec_zero) begin
            w_state_nxt = S_DONE;
            w_hold_nxt  = '0;
          end
        end
      end
      S_PAUSE: begin
        if (w_ev_clear || w_ev_stop) begin
          w_state_nxt = S_SET;
          w_min_nxt   = '0;
          w_sect_nxt  = '0;
          w_seco_nxt  = '0;
        end else if (w_ev_start && door_closed) begin
          w_state_nxt = S_COOK;
        end
      end
      S_DONE: begin
        w_min_nxt  = '0;
        w_sect_nxt = '0;
        w_seco_nxt = '0;
        if (w_ev_clear || w_ev_stop || w_ev_start || w_ev_digit) begin
          w_state_nxt = S_SET;
          w_hold_nxt  = '0;
        end else if (w_ev_tick) begin
          if ((r_hold + HW'(1)) == HW'(DONE_HOLD)) begin
            w_state_nxt = S_SET;
            w_hold_nxt  = '0;
          end else begin
            w_hold_nxt = r_hold + HW'(1);
          end
        end
      end
      default: w_state_nxt = S_SET;
    endcase
  end

  // State, time and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_SET;
      r_min    <= '0;
      r_sect   <= '0;
      r_seco   <= '0;
      r_hold   <= '0;
      r_mag_on <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_min    <= w_min_nxt;
      r_sect   <= w_sect_nxt;
      r_seco   <= w_seco_nxt;
      r_hold   <= w_hold_nxt;
      r_mag_on <= (w_state_nxt == S_COOK);
      r_done   <= (w_state_nxt == S_DONE);
    end
  end

  assign min_d  = r_min;
  assign sec_t  = r_sect;
  assign sec_o  = r_seco;
  assign mag_on = r_mag_on;
  assign done   = r_done;
  assign state  = r_state;

endmodule

// File: tb/tb_cook_timer_ctrl.sv
// Testbench for cook_timer_ctrl: directed scenarios plus randomized traffic
// checked against a minutes/seconds reference model.
module tb_cook_timer_ctrl;

  localparam int HOLD = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] digit = 4'd0;
  logic       digit_stb = 1'b0;
  logic       tick_1hz = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       clear = 1'b0;
  logic       door_closed = 1'b1;
  logic [3:0] min_d, sec_t, sec_o;
  logic       mag_on, done;
  logic [1:0] state;

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model: phase, minutes, seconds as a 0..99 number, hold count
  int m_state = 0;
  int m_min = 0;
  int m_sec = 0;
  int m_hold = 0;

  cook_timer_ctrl #(.DONE_HOLD(HOLD)) dut (
    .clk(clk), .reset(reset), .digit(digit), .digit_stb(digit_stb),
    .tick_1hz(tick_1hz), .start(start), .stop(stop), .clear(clear),
    .door_closed(door_closed), .min_d(min_d), .sec_t(sec_t), .sec_o(sec_o),
    .mag_on(mag_on), .done(done), .state(state)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] pack(int st, bit mg, bit dn, int mi, int t, int o);
    return {2'(st), mg, dn, 4'(mi), 4'(t), 4'(o)};
  endfunction

  function automatic logic [15:0] exp_vec();
    return pack(m_state, m_state == 1, m_state == 3, m_min, m_sec / 10, m_sec % 10);
  endfunction

  function automatic logic [15:0] obs_vec();
    return {state, mag_on, done, min_d, sec_t, sec_o};
  endfunction

  // Apply the rules to the inputs present at this edge
  task automatic model_step();
    int ev;
    int v;
    if (reset) begin
      m_state = 0; m_min = 0; m_sec = 0; m_hold = 0;
      return;
    end
    ev = clear ? 1 : stop ? 2 : start ? 3 : digit_stb ? 4 : tick_1hz ? 5 : 0;
    case (m_state)
      0: begin
        if (ev == 1) begin
          m_min = 0; m_sec = 0;
        end else if (ev == 3 && door_closed) begin
          if (m_min != 0 || m_sec != 0) m_state = 1;
`ifdef COOK_TIMER_QUICK_START_EN
          else begin
            m_sec = 30; m_state = 1;
          end
`endif
        end else if (ev == 4 && int'(digit) <= 9) begin
          v = ((m_min * 100 + m_sec) * 10 + int'(digit)) % 1000;
          m_min = v / 100;
          m_sec = v % 100;
        end
      end
      1: begin
        if (!door_closed || ev == 2) begin
          m_state = 2;
        end else if (ev == 3) begin
`ifdef COOK_TIMER_QUICK_START_EN
          m_sec = m_sec + 30;
          if (m_sec >= 60) begin
            m_sec = m_sec - 60; m_min = m_min + 1;
          end
          if (m_min > 9) begin
            m_min = 9; m_sec = 59;
          end
`endif
        end else if (ev == 5) begin
          if (m_sec > 0) m_sec = m_sec - 1;
          else begin
            m_min = m_min - 1; m_sec = 59;
          end
          if (m_min == 0 && m_sec == 0) begin
            m_state = 3; m_hold = 0;
          end
        end
      end
      2: begin
        if (ev == 1 || ev == 2) begin
          m_state = 0; m_min = 0; m_sec = 0;
        end else if (ev == 3 && door_closed) begin
          m_state = 1;
        end
      end
      default: begin
        if (ev >= 1 && ev <= 4) begin
          m_state = 0; m_hold = 0;
        end else if (ev == 5) begin
          m_hold = m_hold + 1;
          if (m_hold == HOLD) begin
            m_state = 0; m_hold = 0;
          end
        end
      end
    endcase
  endtask

  // Advance one clock with the currently driven inputs, then drop strobes
  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    reset = 1'b0; digit_stb = 1'b0; tick_1hz = 1'b0;
    start = 1'b0; stop = 1'b0; clear = 1'b0;
  endtask

  task automatic key(input int d);
    digit = 4'(d); digit_stb = 1'b1; step();
  endtask

  task automatic tick();
    tick_1hz = 1'b1; step();
  endtask

  task automatic test_reset();
    reset = 1'b1; step();
    reset = 1'b1; step();
    n_cmp++;
    if (obs_vec() !== pack(0, 0, 0, 0, 0, 0)) begin
      n_fail++; $display("FAIL reset_state got=%h want=%h", obs_vec(), pack(0, 0, 0, 0, 0, 0));
    end
  endtask

  task automatic test_basic_cook();
    key(1); key(3); key(0);
    door_closed = 1'b1; start = 1'b1; step();
    n_cmp++;
    if (obs_vec() !== pack(1, 1, 0, 1, 3, 0)) begin
      n_fail++; $display("FAIL basic_start got=%h want=%h", obs_vec(), pack(1, 1, 0, 1, 3, 0));
    end
    for (int i = 1; i < 90; i++) begin
      tick();
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL basic_count tick=%0d got=%h want=%h", i, obs_vec(), exp_vec());
      end
    end
    tick();
    n_cmp++;
    if (obs_vec() !== pack(3, 0, 1, 0, 0, 0)) begin
      n_fail++; $display("FAIL basic_done got=%h want=%h", obs_vec(), pack(3, 0, 1, 0, 0, 0));
    end
    tick(); tick();
    n_cmp++;
    if (obs_vec() !== pack(3, 0, 1, 0, 0, 0)) begin
      n_fail++; $display("FAIL basic_hold got=%h want=%h", obs_vec(), pack(3, 0, 1, 0, 0, 0));
    end
    tick();
    n_cmp++;
    if (obs_vec() !== pack(0, 0, 0, 0, 0, 0)) begin
      n_fail++; $display("FAIL basic_return got=%h want=%h", obs_vec(), pack(0, 0, 0, 0, 0, 0));
    end
  endtask

  task automatic test_unnormalised();
    logic [15:0] want;
    key(0); key(7); key(5);
    start = 1'b1; tick_1hz = 1'b1; step();
    n_cmp++;
    if (obs_vec() !== pack(1, 1, 0, 0, 7, 5)) begin
      n_fail++; $display("FAIL start_tick_dropped got=%h want=%h", obs_vec(), pack(1, 1, 0, 0, 7, 5));
    end
    for (int i = 1; i <= 75; i++) begin
      tick();
      want = (i < 75) ? pack(1, 1, 0, 0, (75 - i) / 10, (75 - i) % 10) : pack(3, 0, 1, 0, 0, 0);
      n_cmp++;
      if (obs_vec() !== want) begin
        n_fail++; $display("FAIL unnorm_count tick=%0d got=%h want=%h", i, obs_vec(), want);
      end
    end
    key(8);
    n_cmp++;
    if (obs_vec() !== pack(0, 0, 0, 0, 0, 0)) begin
      n_fail++; $display("FAIL done_digit_exit got=%h want=%h", obs_vec(), pack(0, 0, 0, 0, 0, 0));
    end
  endtask

  task automatic test_door_pause();
    key(0); key(4); key(5);
    start = 1'b1; step();
    tick(); tick(); tick();
    n_cmp++;
    if (obs_vec() !== pack(1, 1, 0, 0, 4, 2)) begin
      n_fail++; $display("FAIL door_pre got=%h want=%h", obs_vec(), pack(1, 1, 0, 0, 4, 2));
    end
    door_closed = 1'b0; step();
    n_cmp++;
    if (obs_vec() !== pack(2, 0, 0, 0, 4, 2)) begin
      n_fail++; $display("FAIL door_open got=%h want=%h", obs_vec(), pack(2, 0, 0, 0, 4, 2));
    end
    tick(); tick();
    start = 1'b1; step();
    n_cmp++;
    if (obs_vec() !== pack(2, 0, 0, 0, 4, 2)) begin
      n_fail++; $display("FAIL door_hold got=%h want=%h", obs_vec(), pack(2, 0, 0, 0, 4, 2));
    end
    door_closed = 1'b1; start = 1'b1; step();
    n_cmp++;
    if (obs_vec() !== pack(1, 1, 0, 0, 4, 2)) begin
      n_fail++; $display("FAIL door_resume got=%h want=%h", obs_vec(), pack(1, 1, 0, 0, 4, 2));
    end
    tick();
    n_cmp++;
    if (obs_vec() !== pack(1, 1, 0, 0, 4, 1)) begin
      n_fail++; $display("FAIL door_recount got=%h want=%h", obs_vec(), pack(1, 1, 0, 0, 4, 1));
    end
  endtask

  task automatic test_stop_tick();
    reset = 1'b1; step();
    key(0); key(1); key(0);
    start = 1'b1; step();
    stop = 1'b1; tick_1hz = 1'b1; step();
    n_cmp++;
    if (obs_vec() !== pack(2, 0, 0, 0, 1, 0)) begin
      n_fail++; $display("FAIL stop_tick got=%h want=%h", obs_vec(), pack(2, 0, 0, 0, 1, 0));
    end
    stop = 1'b1; step();
    n_cmp++;
    if (obs_vec() !== pack(0, 0, 0, 0, 0, 0)) begin
      n_fail++; $display("FAIL pause_stop got=%h want=%h", obs_vec(), pack(0, 0, 0, 0, 0, 0));
    end
    key(1); key(0); key(1);
    start = 1'b1; step();
    tick(); tick();
    n_cmp++;
    if (obs_vec() !== pack(1, 1, 0, 0, 5, 9)) begin
      n_fail++; $display("FAIL minute_borrow got=%h want=%h", obs_vec(), pack(1, 1, 0, 0, 5, 9));
    end
  endtask

  task automatic test_digits_reset();
    reset = 1'b1; step();
    key(4); key(5); key(6); key(7);
    n_cmp++;
    if (obs_vec() !== pack(0, 0, 0, 5, 6, 7)) begin
      n_fail++; $display("FAIL digit_shift got=%h want=%h", obs_vec(), pack(0, 0, 0, 5, 6, 7));
    end
    key(12);
    n_cmp++;
    if (obs_vec() !== pack(0, 0, 0, 5, 6, 7)) begin
      n_fail++; $display("FAIL digit_invalid got=%h want=%h", obs_vec(), pack(0, 0, 0, 5, 6, 7));
    end
    door_closed = 1'b0; start = 1'b1; step();
    door_closed = 1'b1;
    n_cmp++;
    if (obs_vec() !== pack(0, 0, 0, 5, 6, 7)) begin
      n_fail++; $display("FAIL start_door_open got=%h want=%h", obs_vec(), pack(0, 0, 0, 5, 6, 7));
    end
    clear = 1'b1; step();
    key(2); key(0); key(0);
    start = 1'b1; step();
    n_cmp++;
    if (obs_vec() !== pack(1, 1, 0, 2, 0, 0)) begin
      n_fail++; $display("FAIL cook_200 got=%h want=%h", obs_vec(), pack(1, 1, 0, 2, 0, 0));
    end
    reset = 1'b1; step();
    n_cmp++;
    if (obs_vec() !== pack(0, 0, 0, 0, 0, 0)) begin
      n_fail++; $display("FAIL reset_mid_cook got=%h want=%h", obs_vec(), pack(0, 0, 0, 0, 0, 0));
    end
  endtask

  task automatic test_quick_start();
    logic [15:0] want;
    reset = 1'b1; step();
    start = 1'b1; step();
`ifdef COOK_TIMER_QUICK_START_EN
    want = pack(1, 1, 0, 0, 3, 0);
`else
    want = pack(0, 0, 0, 0, 0, 0);
`endif
    n_cmp++;
    if (obs_vec() !== want) begin
      n_fail++; $display("FAIL zero_start got=%h want=%h", obs_vec(), want);
    end
    reset = 1'b1; step();
    key(9); key(4); key(5);
    start = 1'b1; step();
    start = 1'b1; step();
`ifdef COOK_TIMER_QUICK_START_EN
    want = pack(1, 1, 0, 9, 5, 9);
`else
    want = pack(1, 1, 0, 9, 4, 5);
`endif
    n_cmp++;
    if (obs_vec() !== want) begin
      n_fail++; $display("FAIL cook_start got=%h want=%h", obs_vec(), want);
    end
    reset = 1'b1; step();
  endtask

  task automatic test_random();
    for (int i = 0; i < 4000; i++) begin
      reset       = ($urandom_range(0, 299) == 0);
      clear       = ($urandom_range(0, 49) == 0);
      stop        = ($urandom_range(0, 59) == 0);
      start       = ($urandom_range(0, 9) == 0);
      digit_stb   = ($urandom_range(0, 4) == 0);
      digit       = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15))
                                                : 4'($urandom_range(0, 9));
      tick_1hz    = ($urandom_range(0, 1) == 0);
      door_closed = ($urandom_range(0, 19) != 0);
      step();
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL random cyc=%0d got=%h want=%h", i, obs_vec(), exp_vec());
      end
    end
    door_closed = 1'b1;
  endtask

  initial begin
    #2;
    test_reset();
    test_basic_cook();
    test_unnormalised();
    test_door_pause();
    test_stop_tick();
    test_digits_reset();
    test_quick_start();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
